// File: rtl/div_frec_sched.sv
// div_frec_sched: round-robin scheduler sharing one programmable frequency divider among four requesters.
// Each grant loads the winner's divisor and tick count, emits a burst of divided ticks, then pulses done.
module div_frec_sched #(
    parameter int N_REQ = 4,
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DIV_W-1:0]   div_in,
    input  logic [N_REQ*CNT_W-1:0]   nticks_in,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     tick,
    output logic                     clkd,
    output logic [N_REQ-1:0]         done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_ptr;
    logic [N_REQ-1:0] r_grant;
    logic             r_tick;
    logic             r_clkd;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_rem;
    logic [1:0]       w_pick;
    logic             w_wrap;

    // Scan offsets from farthest to nearest so the nearest requester after r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = N_REQ; k >= 1; k--)
            if (req[r_ptr + 2'(k)]) w_pick = r_ptr + 2'(k);
    end

    assign w_wrap = r_cnt == r_div;
    assign grant  = r_grant;
    assign tick   = r_tick;
    assign clkd   = r_clkd;
    assign busy   = r_state != S_IDLE;
    assign done   = r_state == S_DONE ? r_grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd3;
            r_grant <= '0;
            r_tick  <= 1'b0;
            r_clkd  <= 1'b0;
            r_cnt   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tick <= 1'b0;
                    if (|req) begin
                        r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_ptr   <= w_pick;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_div   <= div_in[r_ptr*DIV_W +: DIV_W];
                    r_rem   <= nticks_in[r_ptr*CNT_W +: CNT_W];
                    r_cnt   <= '0;
                    r_state <= nticks_in[r_ptr*CNT_W +: CNT_W] == '0 ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
                    r_tick <= w_wrap;
                    if (w_wrap) begin
                        r_clkd <= ~r_clkd;
                        r_rem  <= r_rem - 1'b1;
                    end
                    // Dropping the request aborts the burst; a tick on this edge still goes out.
                    if (!req[r_ptr] || (w_wrap && r_rem == CNT_W'(1))) r_state <= S_DONE;
                end
                default: begin
                    r_tick  <= 1'b0;
                    r_clkd  <= 1'b0;
                    r_cnt   <= '0;
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_frec_sched.sv
// tb_div_frec_sched: randomized and directed bench for div_frec_sched against a cycle-arithmetic burst model.
module tb_div_frec_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] div_in = '0;
    logic [31:0] nticks_in = '0;
    logic [3:0]  grant, done;
    logic        busy, tick, clkd;
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_ptr = 3;

    div_frec_sched dut (
        .clk(clk), .rst(rst), .req(req), .div_in(div_in), .nticks_in(nticks_in),
        .grant(grant), .busy(busy), .tick(tick), .clkd(clkd), .done(done)
    );

    always #5 clk = ~clk;

    // Runs one burst from an IDLE cycle with req already driven. Expected waveforms follow
    // from the winner's divisor d and count t: ticks every d+1 cycles starting d+3 after the sample.
    task automatic burst(input int abort_at, input bit scramble);
        int g, d, t, e_nat, e_done, nt;
        logic [3:0] oh, eg, ed;
        logic eb, et, ec;
        g = -1;
        for (int k = 1; k <= 4; k++)
            if (g < 0 && req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        if (g < 0) begin
            n_cmp++; n_err++;
            $display("FAIL burst_setup: req=%b has no requester to grant", req);
            return;
        end
        d = int'(div_in[16*g +: 16]);
        t = int'(nticks_in[8*g +: 8]);
        oh = 4'b0001 << g;
        e_nat = t == 0 ? 2 : (d + 1) * t + 2;
        e_done = (abort_at >= 0 && t > 0 && 3 + abort_at < e_nat) ? 3 + abort_at : e_nat;
        for (int n = 1; n <= e_done + 1; n++) begin
            @(posedge clk); #1;
            nt = n >= 2 ? (n - 2) / (d + 1) : 0;
            eb = n <= e_done;
            eg = eb ? oh : 4'b0000;
            ed = n == e_done ? oh : 4'b0000;
            et = n >= 3 && n <= e_done && (n - 2) % (d + 1) == 0;
            ec = n <= e_done && nt % 2 == 1;
            n_cmp++; if (grant !== eg) begin n_err++; $display("FAIL grant n=%0d g=%0d got=%b exp=%b", n, g, grant, eg); end
            n_cmp++; if (busy !== eb) begin n_err++; $display("FAIL busy n=%0d g=%0d got=%b exp=%b", n, g, busy, eb); end
            n_cmp++; if (tick !== et) begin n_err++; $display("FAIL tick n=%0d g=%0d d=%0d got=%b exp=%b", n, g, d, tick, et); end
            n_cmp++; if (clkd !== ec) begin n_err++; $display("FAIL clkd n=%0d g=%0d d=%0d got=%b exp=%b", n, g, d, clkd, ec); end
            n_cmp++; if (done !== ed) begin n_err++; $display("FAIL done n=%0d g=%0d got=%b exp=%b", n, g, done, ed); end
            if (scramble && n == 2) begin
                div_in = {$urandom, $urandom};
                nticks_in = $urandom;
            end
            if (abort_at >= 0 && e_done < e_nat && n == 2 + abort_at) req[g] = 1'b0;
        end
        m_ptr = g;
    endtask

    task automatic test_reset();
        req = 4'($urandom_range(1, 15));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if ({grant, busy, tick, clkd, done} !== 11'd0)
                begin n_err++; $display("FAIL reset_outputs got=%b exp=0", {grant, busy, tick, clkd, done}); end
        end
        req = '0;
        rst = 1'b0;
        m_ptr = 3;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_burst();
        div_in[15:0] = 16'h01F3;
        nticks_in[7:0] = 8'd3;
        req = 4'b0001;
        burst(-1, 1'b0);
        req = '0;
    endtask

    task automatic test_round_robin();
        div_in = {4{16'd4}};
        nticks_in = {4{8'd2}};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) burst(-1, 1'b0);
        req = '0;
    endtask

    task automatic test_div_zero();
        div_in[47:32] = 16'd0;
        nticks_in[23:16] = 8'd5;
        req = 4'b0100;
        burst(-1, 1'b0);
        req = '0;
    endtask

    task automatic test_zero_ticks();
        nticks_in[15:8] = 8'd0;
        req = 4'b0010;
        burst(-1, 1'b0);
        req = '0;
    endtask

    task automatic test_abort();
        div_in[15:0] = 16'd9;
        nticks_in[7:0] = 8'd10;
        req = 4'b0001;
        burst(25, 1'b0);
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        div_in[15:0] = 16'd29;
        nticks_in[7:0] = 8'd5;
        req = 4'b0001;
        repeat (52) @(posedge clk);
        #1;
        n_cmp++; if (clkd !== 1'b1) begin n_err++; $display("FAIL midrun_clkd got=%b exp=1", clkd); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({grant, busy, tick, clkd, done} !== 11'd0)
            begin n_err++; $display("FAIL midrun_reset got=%b exp=0", {grant, busy, tick, clkd, done}); end
        rst = 1'b0;
        m_ptr = 3;
        div_in[15:0] = 16'd2;
        nticks_in[7:0] = 8'd2;
        div_in[63:48] = 16'd1;
        nticks_in[31:24] = 8'd1;
        req = 4'b1001;
        burst(-1, 1'b0);
        burst(-1, 1'b0);
        req = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 4; r++) begin
                div_in[16*r +: 16] = 16'($urandom_range(0, 9));
                nticks_in[8*r +: 8] = 8'($urandom_range(0, 4));
            end
            req = 4'($urandom_range(1, 15));
            burst($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 30)) : -1, 1'($urandom));
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_div_zero();
        test_zero_ticks();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
